// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if
//   Bundles the FIFO read pins and the downstream valid/ready stream.
//   master : the reader (drives r_en, m_valid, m_data).
//   slave  : the environment (drives empty, rdata, m_ready).
//   Signals:
//     empty   FIFO empty flag (registered in the FIFO)
//     rdata   FIFO read data, valid the cycle after an accepted r_en
//     r_en    read request to the FIFO
//     m_valid output word available
//     m_ready consumer accepts the word
//     m_data  head-of-buffer word
interface fifo_stream_reader_if #(
   parameter int unsigned MEMORY_WIDTH = 4
) ();
   logic                    empty;
   logic [MEMORY_WIDTH-1:0] rdata;
   logic                    r_en;
   logic                    m_valid;
   logic                    m_ready;
   logic [MEMORY_WIDTH-1:0] m_data;

   modport master (
      input  empty, rdata, m_ready,
      output r_en, m_valid, m_data
   );

   modport slave (
      output empty, rdata, m_ready,
      input  r_en, m_valid, m_data
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side drain controller for a synchronous FIFO. Issues reads into a
//   3-entry circular buffer that absorbs the FIFO's one-cycle read latency
//   and presents the head word on a valid/ready stream. r_en is derived
//   from registered state and empty only, never from m_ready.
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     bus        fifo_stream_reader_if.master (FIFO pins + output stream)
//     words_out  completed transfer count (only with FIFO_READER_CNT_EN)
//   Optional feature macro: FIFO_READER_CNT_EN enables the words_out counter.
module fifo_stream_reader #(
   parameter int unsigned MEMORY_WIDTH = 4,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef FIFO_READER_CNT_EN
   fifo_stream_reader_if.master bus,
   output logic [CNT_WIDTH-1:0] words_out
`else
   fifo_stream_reader_if.master bus
`endif
);

   if (MEMORY_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
      $error("fifo_stream_reader: MEMORY_WIDTH and CNT_WIDTH must be >= 1");
   end

   logic [MEMORY_WIDTH-1:0] buf_q [3];
   logic [1:0]              occ_q, occ_d;
   logic                    inflight_q, inflight_d;
   logic [1:0]              head_q, head_d;
   logic [1:0]              tail_q, tail_d;
   logic [2:0]              level;
   logic                    pop;
   logic                    rd;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   always_comb begin
      // Buffered plus in-flight words; a read is only issued when the word
      // it returns is guaranteed a free slot.
      level      = {1'b0, occ_q} + {2'b00, inflight_q};
      rd         = !bus.empty && (level < 3'd3);
      pop        = (occ_q != 2'd0) && bus.m_ready;
      inflight_d = rd;
      occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
      head_d     = pop        ? ptr_inc(head_q) : head_q;
      tail_d     = inflight_q ? ptr_inc(tail_q) : tail_q;
   end

   assign bus.r_en    = rd;
   assign bus.m_valid = (occ_q != 2'd0);
   assign bus.m_data  = (occ_q != 2'd0) ? buf_q[head_q] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q      <= '0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         for (int unsigned i = 0; i < 3; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         // Capture slot differs from the popped slot because level <= 3.
         if (inflight_q) begin
            buf_q[tail_q] <= bus.rdata;
         end
      end
   end

`ifdef FIFO_READER_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (pop) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign words_out = cnt_q;
`endif

   a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
      level <= 3'd3);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//   Directed bench for fifo_stream_reader with a small 4-deep FIFO model
//   (registered empty flag, one-cycle registered read data).
module tb_fifo_stream_reader;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   int   bad_reads;

   fifo_stream_reader_if #(.MEMORY_WIDTH(4)) bus ();

`ifdef FIFO_READER_CNT_EN
   logic [15:0] words_out;
   fifo_stream_reader #(.MEMORY_WIDTH(4), .CNT_WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .words_out (words_out)
   );
`else
   fifo_stream_reader #(.MEMORY_WIDTH(4), .CNT_WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model
   logic       wr_en;
   logic [3:0] wr_data;
   logic [3:0] fq [$];
   logic       empty_r;
   logic [3:0] rdata_r;
   int         fifo_n;

   assign bus.empty = empty_r;
   assign bus.rdata = rdata_r;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fq.delete();
         empty_r <= 1'b1;
         rdata_r <= '0;
      end else begin
         fifo_n = fq.size();
         if (bus.r_en) begin
            if (fifo_n == 0) begin
               bad_reads++;
            end else begin
               rdata_r <= fq.pop_front();
               fifo_n--;
            end
         end
         if (wr_en && fifo_n < 4) begin
            fq.push_back(wr_data);
            fifo_n++;
         end
         empty_r <= (fifo_n == 0);
      end
   end

   logic [3:0] got [$];

   task automatic tick();
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      wr_en = 1'b0;
      bus.m_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      got.delete();
   endtask

   task automatic preload4();
      for (int i = 1; i <= 4; i++) fq.push_back(4'(i));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wr_en = 1'b0;
      bus.m_ready = 1'b0;
      tick();
      tick();
      n_checks++; if (bus.r_en !== 1'b0) $display("FAIL reset_r_en: got %b expected 0", bus.r_en); else n_pass++;
      n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); else n_pass++;
      n_checks++; if (bus.m_data !== 4'h0) $display("FAIL reset_m_data: got %h expected 0", bus.m_data); else n_pass++;
`ifdef FIFO_READER_CNT_EN
      n_checks++; if (words_out !== 16'd0) $display("FAIL reset_words_out: got %0d expected 0", words_out); else n_pass++;
`endif
      rst_n = 1'b1;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++; if (bus.r_en !== 1'b0) $display("FAIL idle_r_en[%0d]: got %b expected 0", i, bus.r_en); else n_pass++;
         n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL idle_m_valid[%0d]: got %b expected 0", i, bus.m_valid); else n_pass++;
         n_checks++; if (bus.m_data !== 4'h0) $display("FAIL idle_m_data[%0d]: got %h expected 0", i, bus.m_data); else n_pass++;
      end
   endtask

   task automatic test_single_word();
      apply_reset();
      bus.m_ready = 1'b1;
      wr_en = 1'b1;
      wr_data = 4'hA;
      tick();
      wr_en = 1'b0;
      n_checks++; if (bus.r_en !== 1'b1) $display("FAIL single_r_en: got %b expected 1", bus.r_en); else n_pass++;
      tick();
      n_checks++; if (bus.r_en !== 1'b0) $display("FAIL single_r_en_drop: got %b expected 0", bus.r_en); else n_pass++;
      n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL single_valid_early: got %b expected 0", bus.m_valid); else n_pass++;
      tick();
      n_checks++; if (bus.m_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", bus.m_valid); else n_pass++;
      n_checks++; if (bus.m_data !== 4'hA) $display("FAIL single_data: got %h expected a", bus.m_data); else n_pass++;
      tick();
      n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL single_valid_after: got %b expected 0", bus.m_valid); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (bus.r_en !== 1'b0) $display("FAIL single_no_reread[%0d]: got %b expected 0", i, bus.r_en); else n_pass++;
         tick();
      end
      n_checks++; if (got.size() != 1) $display("FAIL single_count: got %0d expected 1", got.size()); else n_pass++;
   endtask

   task automatic test_streaming();
      apply_reset();
      bus.m_ready = 1'b1;
      preload4();
      tick();
      tick();
      tick();
      for (int k = 1; k <= 4; k++) begin
         n_checks++; if (bus.m_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b expected 1", k, bus.m_valid); else n_pass++;
         n_checks++; if (bus.m_data !== 4'(k)) $display("FAIL stream_data[%0d]: got %h expected %h", k, bus.m_data, 4'(k)); else n_pass++;
         tick();
      end
      n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL stream_valid_end: got %b expected 0", bus.m_valid); else n_pass++;
`ifdef FIFO_READER_CNT_EN
      n_checks++; if (words_out !== 16'd4) $display("FAIL stream_words_out: got %0d expected 4", words_out); else n_pass++;
`endif
   endtask

   task automatic test_backpressure();
      apply_reset();
      bus.m_ready = 1'b0;
      preload4();
      for (int i = 0; i < 4; i++) tick();
      n_checks++; if (bus.r_en !== 1'b0) $display("FAIL bp_r_en_full: got %b expected 0", bus.r_en); else n_pass++;
      for (int i = 5; i <= 8; i++) begin
         tick();
         n_checks++; if (bus.r_en !== 1'b0) $display("FAIL bp_r_en[%0d]: got %b expected 0", i, bus.r_en); else n_pass++;
         n_checks++; if (bus.m_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b expected 1", i, bus.m_valid); else n_pass++;
         n_checks++; if (bus.m_data !== 4'h1) $display("FAIL bp_data[%0d]: got %h expected 1", i, bus.m_data); else n_pass++;
      end
      n_checks++; if (dut.occ_q !== 2'd3) $display("FAIL bp_occ: got %0d expected 3", dut.occ_q); else n_pass++;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      n_checks++; if (got.size() != 4) $display("FAIL bp_count: got %0d expected 4", got.size()); else n_pass++;
      for (int k = 0; k < 4 && k < got.size(); k++) begin
         n_checks++; if (got[k] !== 4'(k + 1)) $display("FAIL bp_order[%0d]: got %h expected %h", k, got[k], 4'(k + 1)); else n_pass++;
      end
   endtask

   task automatic test_random_stream();
      logic [3:0] vec [20];
      logic [3:0] prev;
      logic       stall;
      int         sent;
      int         cyc;
      apply_reset();
      for (int i = 0; i < 20; i++) vec[i] = 4'($urandom_range(0, 15));
      sent = 0;
      cyc  = 0;
      while (got.size() < 20 && cyc < 400) begin
         bus.m_ready = 1'($urandom_range(0, 1));
         if (sent < 20 && fq.size() < 3 && $urandom_range(0, 3) != 0) begin
            wr_en   = 1'b1;
            wr_data = vec[sent];
            sent++;
         end else begin
            wr_en = 1'b0;
         end
         stall = bus.m_valid && !bus.m_ready;
         prev  = bus.m_data;
         tick();
         cyc++;
         if (stall) begin
            n_checks++; if (bus.m_valid !== 1'b1) $display("FAIL rnd_valid_hold@%0d: got %b expected 1", cyc, bus.m_valid); else n_pass++;
            n_checks++; if (bus.m_data !== prev) $display("FAIL rnd_data_hold@%0d: got %h expected %h", cyc, bus.m_data, prev); else n_pass++;
         end
      end
      wr_en = 1'b0;
      bus.m_ready = 1'b0;
      n_checks++; if (got.size() != 20) $display("FAIL rnd_count: got %0d expected 20", got.size()); else n_pass++;
      for (int i = 0; i < 20 && i < got.size(); i++) begin
         n_checks++; if (got[i] !== vec[i]) $display("FAIL rnd_order[%0d]: got %h expected %h", i, got[i], vec[i]); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      bus.m_ready = 1'b0;
      preload4();
      for (int i = 0; i < 4; i++) tick();
      n_checks++; if (dut.occ_q !== 2'd2) $display("FAIL mid_occ: got %0d expected 2", dut.occ_q); else n_pass++;
      n_checks++; if (dut.inflight_q !== 1'b1) $display("FAIL mid_inflight: got %b expected 1", dut.inflight_q); else n_pass++;
      rst_n = 1'b0;
      tick();
      n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL mid_valid: got %b expected 0", bus.m_valid); else n_pass++;
      n_checks++; if (bus.r_en !== 1'b0) $display("FAIL mid_r_en: got %b expected 0", bus.r_en); else n_pass++;
      n_checks++; if (bus.m_data !== 4'h0) $display("FAIL mid_m_data: got %h expected 0", bus.m_data); else n_pass++;
`ifdef FIFO_READER_CNT_EN
      n_checks++; if (words_out !== 16'd0) $display("FAIL mid_words_out: got %0d expected 0", words_out); else n_pass++;
`endif
      rst_n = 1'b1;
      tick();
      got.delete();
      bus.m_ready = 1'b1;
      wr_en = 1'b1;
      wr_data = 4'h5;
      tick();
      wr_en = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      n_checks++; if (got.size() != 1) $display("FAIL mid_after_count: got %0d expected 1", got.size()); else n_pass++;
      if (got.size() > 0) begin
         n_checks++; if (got[0] !== 4'h5) $display("FAIL mid_after_data: got %h expected 5", got[0]); else n_pass++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      bad_reads   = 0;
      rst_n       = 1'b0;
      wr_en       = 1'b0;
      wr_data     = '0;
      bus.m_ready = 1'b0;
      test_reset();
      test_single_word();
      test_streaming();
      test_backpressure();
      test_random_stream();
      test_reset_mid();
      n_checks++; if (bad_reads !== 0) $display("FAIL read_on_empty: got %0d expected 0", bad_reads); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain controller for the synchronous FIFO.
- Sits between the FIFO's `r_en`/`empty`/`rdata` pins and a downstream valid/ready consumer.
- Absorbs the FIFO's one-cycle registered read latency with a 3-entry output buffer.
- Sustains one word per cycle under continuous `m_ready`, with no combinational path from `m_ready` to `r_en`.

## Interface
- `MEMORY_WIDTH`, default 4: word width; must match the FIFO's `MEMORY_WIDTH`.
- `CNT_WIDTH`, default 16: width of the transfer counter (used only with `FIFO_READER_CNT_EN`).
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `empty`  input  1  FIFO empty flag, registered in the FIFO.
- `rdata`  input  MEMORY_WIDTH  FIFO read data, valid the cycle after an accepted `r_en`.
- `r_en`  output  1  read request to the FIFO.
- `m_valid`  output  1  output word available.
- `m_ready`  input  1  consumer accepts the word.
- `m_data`  output  MEMORY_WIDTH  head-of-buffer word.
- `words_out`  output  CNT_WIDTH  completed transfers (only with `FIFO_READER_CNT_EN`).

## Operation
- State:
  - `occ`: registered, 0..3, buffer occupancy.
  - `inflight`: registered, 0/1; set to 1 on any cycle with `r_en`=1, otherwise 0.
  - Buffer: 3-entry circular array, 2-bit head and tail pointers wrapping 2->0.
- Read issue: `r_en` = `!empty && (occ + inflight < 3)`.
  - Evaluated from registered state and `empty` only; never depends on `m_ready`.
- Capture: when `inflight`=1, `rdata` is written at `tail` and `tail` advances.
- Pop: when `m_valid && m_ready`, `head` advances.
- Occupancy update: `occ_next` = `occ + inflight - pop`.
  - Simultaneous capture and pop leave `occ` unchanged.
  - Capture into slot `tail` while popping slot `head` is legal; `occ + inflight <= 3` guarantees the slots differ.
- Outputs:
  - `m_valid` = (`occ` != 0).
  - `m_data` = `buf[head]`, or 0 when `occ`=0.
  - `m_data` holds stable while `m_valid && !m_ready`.
- Invariant: `occ + inflight <= 3` at all times. An assertion must flag any violation.
- Boundaries:
  - FIFO going empty: `empty` rises on the same edge as the last read is taken, so no read is issued against an empty FIFO.
  - Buffer full (`occ`=3): `r_en`=0 until a pop lowers `occ` at the next edge.
  - Backpressure with `occ`=2, `inflight`=1: the in-flight word lands, `occ` becomes 3, `r_en` is held low.
- Reset (any time, including mid-burst): `occ`, `inflight`, `head` and `tail` return to 0 and buffered words are discarded. The FIFO shares `rst_n`, so no stale read returns after reset.

## Timing
- Reset values: `r_en`=0, `m_valid`=0, `m_data`=0, `words_out`=0.
- Latency: `empty` falls in cycle N with `occ`=0 → `r_en`=1 in cycle N → word captured at the end of N+1 → `m_valid`=1 in cycle N+2.
- Throughput: continuous `m_ready`=1 with a non-empty FIFO gives one word per cycle after the 2-cycle fill.
- Steady-state operating point is `occ`=1, `inflight`=1.
- Handshake rules:
  - Transfer occurs on the edge where `m_valid && m_ready`.
  - `m_valid` never drops without a transfer, except on reset.
  - `m_ready` may be asserted with `m_valid`=0; this has no effect.
- Order is strictly FIFO; no word is dropped or duplicated.

## Configuration
- `FIFO_READER_CNT_EN` defined:
  - `words_out` port exists.
  - It increments by 1 on each transfer and wraps modulo 2^CNT_WIDTH.
  - It resets to 0.
- `FIFO_READER_CNT_EN` undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset then idle: `empty`=1 for 10 cycles → `r_en`=0, `m_valid`=0, `m_data`=0 throughout.
- Single word: FIFO holds 0xA, `m_ready`=1 → one `r_en` pulse, `m_valid` for exactly one cycle with `m_data`=0xA two cycles after `r_en`, no second `r_en`.
- Streaming: write 0x1..0x4 to a full 4-deep FIFO, `m_ready`=1 → `m_data` 0x1,0x2,0x3,0x4 on consecutive cycles; `words_out`=4 with `FIFO_READER_CNT_EN`.
- Backpressure: 4 words queued, `m_ready`=0 for 8 cycles → `occ` reaches 3, `r_en` stays low afterwards, `m_data`=0x1 stable. Then `m_ready`=1 → 0x1..0x4 delivered in order.
- Wrap-around and simultaneous events: 20 random words with random `m_ready` and concurrent FIFO writes → output sequence equals input sequence and the `occ + inflight <= 3` assertion never fires.
- Reset mid-operation: assert `rst_n`=0 with `occ`=2 and `inflight`=1 → next cycle `m_valid`=0, `r_en`=0, `words_out`=0. After release and a new write of 0x5, the first output is 0x5.
